// File: rtl/sudoku_pkg.sv
// Shared constants for the Sudoku game controller: state encodings, cell
// index width and default step-flag durations.
package sudoku_pkg;

  localparam int CELL_IDX_W       = 4;
  localparam int DEF_BOARD_CYCLES = 2;
  localparam int DEF_CHECK_CYCLES = 2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_GEN       = 3'd1;
  localparam state_t S_WAIT_DIFF = 3'd2;
  localparam state_t S_WAIT_ROW  = 3'd3;
  localparam state_t S_WAIT_COL  = 3'd4;
  localparam state_t S_WAIT_VAL  = 3'd5;
  localparam state_t S_CHECK     = 3'd6;
  localparam state_t S_DONE      = 3'd7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_det.sv
// One-bit rising-edge detector. The history register resets to 1 so a level
// already high when reset is released is not mistaken for a fresh press.
module edge_det (
  input  logic clka,
  input  logic restart,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  // Next history value is simply the current input level.
  always_comb d_d = d;

  // History register, forced high by reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of block ordering in the simulator.
  always_ff @(posedge clka) begin
    if (restart) d_q <= 1'b1;
    else         d_q <= d_d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/sudoku_ctrl.sv
// Game-sequencing controller: turns debounced button edges and the 2-bit
// switch value into one-hot datapath step flags, tracks the game state and
// counts accepted moves. Every output is a flop.
module sudoku_ctrl
  import sudoku_pkg::*;
#(
  parameter int BOARD_CYCLES = DEF_BOARD_CYCLES,
  parameter int CHECK_CYCLES = DEF_CHECK_CYCLES
) (
  input  logic                     clka,
  input  logic                     restart,
  input  logic                     new_game_btn,
  input  logic                     enter,
  input  logic [1:0]               sw,
  input  logic                     solved,
  input  logic [2**CELL_IDX_W-1:0] fill_flag,
  output logic                     new_game,
  output logic                     set_board_flag,
  output logic                     set_diff_flag,
  output logic                     row_flag,
  output logic                     col_flag,
  output logic                     val_flag,
  output logic                     check_flag,
  output logic [1:0]               dp_val,
  output logic [2:0]               state,
  output logic                     hint_reject,
  output logic                     game_over,
  output logic [7:0]               move_count
);

  // The counter must be able to hold the larger terminal count itself.
  localparam int CNT_W = $clog2(max_int(BOARD_CYCLES, CHECK_CYCLES) + 1);
  localparam logic [CNT_W-1:0] BOARD_LAST = CNT_W'(BOARD_CYCLES);
  localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(CHECK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic enter_rise;
  logic ng_rise;

  edge_det u_enter_edge (.clka(clka), .restart(restart), .d(enter),        .rise(enter_rise));
  edge_det u_ng_edge    (.clka(clka), .restart(restart), .d(new_game_btn), .rise(ng_rise));

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              row_q, row_d;
  logic [1:0]              dp_val_q, dp_val_d;
  logic [7:0]              move_count_q, move_count_d;
  logic                    new_game_q, new_game_d;
  logic                    set_board_q, set_board_d;
  logic                    set_diff_q, set_diff_d;
  logic                    row_flag_q, row_flag_d;
  logic                    col_flag_q, col_flag_d;
  logic                    val_flag_q, val_flag_d;
  logic                    check_flag_q, check_flag_d;
  logic                    hint_reject_q, hint_reject_d;
  logic                    game_over_q, game_over_d;
  logic [CELL_IDX_W-1:0]   cell_idx;

  assign cell_idx = {row_q, sw};

  // Next-state and next-output logic; a new-game edge overrides any enter edge.
  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    row_d         = row_q;
    dp_val_d      = dp_val_q;
    move_count_d  = move_count_q;
    new_game_d    = 1'b0;
    set_board_d   = 1'b0;
    set_diff_d    = 1'b0;
    row_flag_d    = 1'b0;
    col_flag_d    = 1'b0;
    val_flag_d    = 1'b0;
    check_flag_d  = 1'b0;
    hint_reject_d = 1'b0;

    if (ng_rise) begin
      new_game_d   = 1'b1;
      move_count_d = '0;
      cnt_d        = '0;
      state_d      = S_GEN;
    end else begin
      case (state_q)
        S_GEN: begin
          if (cnt_q == BOARD_LAST) begin
            state_d = S_WAIT_DIFF;
          end else begin
            set_board_d = 1'b1;
            cnt_d       = cnt_q + CNT_ONE;
          end
        end
        S_WAIT_DIFF: begin
          if (enter_rise) begin
            dp_val_d   = sw;
            set_diff_d = 1'b1;
            state_d    = S_WAIT_ROW;
          end
        end
        S_WAIT_ROW: begin
          if (enter_rise) begin
            row_d      = sw;
            dp_val_d   = sw;
            row_flag_d = 1'b1;
            state_d    = S_WAIT_COL;
          end
        end
        S_WAIT_COL: begin
          if (enter_rise) begin
            dp_val_d   = sw;
            col_flag_d = 1'b1;
            if (fill_flag[cell_idx]) begin
              hint_reject_d = 1'b1;
              state_d       = S_WAIT_ROW;
            end else begin
              state_d = S_WAIT_VAL;
            end
          end
        end
        S_WAIT_VAL: begin
          if (enter_rise) begin
            dp_val_d     = sw;
            val_flag_d   = 1'b1;
            check_flag_d = 1'b1;
            cnt_d        = CNT_ONE;
            if (move_count_q != 8'hFF) move_count_d = move_count_q + 8'd1;
            state_d      = S_CHECK;
          end
        end
        S_CHECK: begin
          // The val_flag cycle already counted as check cycle one.
          if (cnt_q == CHECK_LAST) begin
            state_d = solved ? S_DONE : S_WAIT_ROW;
          end else begin
            check_flag_d = 1'b1;
            cnt_d        = cnt_q + CNT_ONE;
          end
        end
        default: ; // IDLE and DONE wait for a new-game edge only
      endcase
    end

    game_over_d = (state_d == S_DONE);
  end

  // Controller registers with synchronous restart.
  always_ff @(posedge clka) begin
    if (restart) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      row_q         <= '0;
      dp_val_q      <= '0;
      move_count_q  <= '0;
      new_game_q    <= 1'b0;
      set_board_q   <= 1'b0;
      set_diff_q    <= 1'b0;
      row_flag_q    <= 1'b0;
      col_flag_q    <= 1'b0;
      val_flag_q    <= 1'b0;
      check_flag_q  <= 1'b0;
      hint_reject_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      dp_val_q      <= dp_val_d;
      move_count_q  <= move_count_d;
      new_game_q    <= new_game_d;
      set_board_q   <= set_board_d;
      set_diff_q    <= set_diff_d;
      row_flag_q    <= row_flag_d;
      col_flag_q    <= col_flag_d;
      val_flag_q    <= val_flag_d;
      check_flag_q  <= check_flag_d;
      hint_reject_q <= hint_reject_d;
      game_over_q   <= game_over_d;
    end
  end

  assign new_game       = new_game_q;
  assign set_board_flag = set_board_q;
  assign set_diff_flag  = set_diff_q;
  assign row_flag       = row_flag_q;
  assign col_flag       = col_flag_q;
  assign val_flag       = val_flag_q;
  assign check_flag     = check_flag_q;
  assign dp_val         = dp_val_q;
  assign state          = state_q;
  assign hint_reject    = hint_reject_q;
  assign game_over      = game_over_q;
  assign move_count     = move_count_q;

endmodule

// File: tb/tb_sudoku_ctrl.sv
// Directed bench for sudoku_ctrl: a vector table for the main game flow plus
// hand-written sequences for held inputs, simultaneous edges, move-count
// saturation and restart during CHECK.
module tb_sudoku_ctrl;

  logic        clka = 1'b0;
  logic        restart = 1'b1;
  logic        new_game_btn = 1'b0;
  logic        enter = 1'b0;
  logic [1:0]  sw = 2'd0;
  logic        solved = 1'b0;
  logic [15:0] fill_flag = 16'h0000;
  logic        new_game, set_board_flag, set_diff_flag, row_flag, col_flag;
  logic        val_flag, check_flag, hint_reject, game_over;
  logic [1:0]  dp_val;
  logic [2:0]  state;
  logic [7:0]  move_count;

  sudoku_ctrl dut (
    .clka(clka), .restart(restart), .new_game_btn(new_game_btn), .enter(enter),
    .sw(sw), .solved(solved), .fill_flag(fill_flag), .new_game(new_game),
    .set_board_flag(set_board_flag), .set_diff_flag(set_diff_flag),
    .row_flag(row_flag), .col_flag(col_flag), .val_flag(val_flag),
    .check_flag(check_flag), .dp_val(dp_val), .state(state),
    .hint_reject(hint_reject), .game_over(game_over), .move_count(move_count)
  );

  always #5 clka = ~clka;

  // flags = {new_game, set_board, set_diff, row, col, val, check, hint_reject}
  typedef struct packed {
    logic [7:0] flags;
    logic [2:0] st;
    logic       go;
    logic [1:0] dp;
    logic [7:0] mc;
  } out_t;

  typedef struct {
    logic        rs, ng, en;
    logic [1:0]  sw;
    logic        solved;
    logic [15:0] fill;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic out_t sample();
    out_t o;
    o.flags = {new_game, set_board_flag, set_diff_flag, row_flag,
               col_flag, val_flag, check_flag, hint_reject};
    o.st = state;
    o.go = game_over;
    o.dp = dp_val;
    o.mc = move_count;
    return o;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got flags=%h state=%0d go=%b dp=%0d mc=%0d, want flags=%h state=%0d go=%b dp=%0d mc=%0d",
               name, got.flags, got.st, got.go, got.dp, got.mc,
               exp.flags, exp.st, exp.go, exp.dp, exp.mc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic add(input logic rs, ng, en, input logic [1:0] s, input logic sol,
                     input logic [15:0] fl, input logic [7:0] ef, input logic [2:0] est,
                     input logic ego, input logic [1:0] edp, input logic [7:0] emc);
    vec_t v;
    v.rs = rs; v.ng = ng; v.en = en; v.sw = s; v.solved = sol; v.fill = fl;
    v.exp = '{flags: ef, st: est, go: ego, dp: edp, mc: emc};
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic press(input logic [1:0] v);
    sw = v; enter = 1'b1; tick();
    enter = 1'b0; tick();
  endtask

  initial begin : main
    int   sd_cnt, row_cnt;
    out_t o;

    //   rs ng en sw sol fill      flags   st go dp mc
    add(1, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0);  // reset state
    add(0, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0);  // enter ignored in IDLE
    add(0, 1, 0, 0, 0, 16'h0000, 8'h80, 1, 0, 0, 0);  // new_game pulse
    add(0, 1, 0, 0, 0, 16'h0000, 8'h40, 1, 0, 0, 0);  // set_board 1
    add(0, 0, 0, 0, 0, 16'h0000, 8'h40, 1, 0, 0, 0);  // set_board 2
    add(0, 0, 0, 0, 0, 16'h0000, 8'h00, 2, 0, 0, 0);  // WAIT_DIFF
    add(0, 0, 1, 2, 0, 16'h0000, 8'h20, 3, 0, 2, 0);  // difficulty 2
    add(0, 0, 0, 1, 0, 16'h0000, 8'h00, 3, 0, 2, 0);
    add(0, 0, 1, 1, 0, 16'h0000, 8'h10, 4, 0, 1, 0);  // row 1
    add(0, 0, 0, 3, 0, 16'h0000, 8'h00, 4, 0, 1, 0);
    add(0, 0, 1, 3, 0, 16'h0000, 8'h08, 5, 0, 3, 0);  // col 3, unlocked
    add(0, 0, 0, 2, 0, 16'h0000, 8'h00, 5, 0, 3, 0);
    add(0, 0, 1, 2, 0, 16'h0000, 8'h06, 6, 0, 2, 1);  // value 2: val+check
    add(0, 0, 0, 2, 0, 16'h0000, 8'h02, 6, 0, 2, 1);  // check cycle 2
    add(0, 0, 0, 2, 0, 16'h0000, 8'h00, 3, 0, 2, 1);  // not solved
    add(0, 0, 1, 1, 0, 16'h0080, 8'h10, 4, 0, 1, 1);  // row 1
    add(0, 0, 0, 3, 0, 16'h0080, 8'h00, 4, 0, 1, 1);
    add(0, 0, 1, 3, 0, 16'h0080, 8'h09, 3, 0, 3, 1);  // locked cell 7
    add(0, 0, 0, 3, 0, 16'h0080, 8'h00, 3, 0, 3, 1);
    add(0, 0, 1, 0, 0, 16'h0080, 8'h10, 4, 0, 0, 1);  // row 0
    add(0, 0, 0, 0, 0, 16'h0080, 8'h00, 4, 0, 0, 1);
    add(0, 0, 1, 0, 0, 16'h0080, 8'h08, 5, 0, 0, 1);  // col 0, unlocked
    add(0, 0, 0, 1, 0, 16'h0080, 8'h00, 5, 0, 0, 1);
    add(0, 0, 1, 1, 1, 16'h0080, 8'h06, 6, 0, 1, 2);  // value 1
    add(0, 0, 0, 1, 1, 16'h0080, 8'h02, 6, 0, 1, 2);
    add(0, 0, 0, 1, 1, 16'h0080, 8'h00, 7, 1, 1, 2);  // solved -> DONE
    add(0, 0, 1, 3, 1, 16'h0080, 8'h00, 7, 1, 1, 2);  // enter ignored in DONE
    add(0, 0, 0, 3, 1, 16'h0080, 8'h00, 7, 1, 1, 2);
    add(0, 1, 0, 3, 0, 16'h0000, 8'h80, 1, 0, 1, 0);  // new game from DONE
    add(0, 0, 0, 3, 0, 16'h0000, 8'h40, 1, 0, 1, 0);
    add(0, 0, 0, 3, 0, 16'h0000, 8'h40, 1, 0, 1, 0);
    add(0, 0, 0, 3, 0, 16'h0000, 8'h00, 2, 0, 1, 0);

    foreach (vecs[i]) begin
      restart = vecs[i].rs; new_game_btn = vecs[i].ng; enter = vecs[i].en;
      sw = vecs[i].sw; solved = vecs[i].solved; fill_flag = vecs[i].fill;
      tick();
      check($sformatf("vec%0d", i), sample(), vecs[i].exp);
    end
    fill_flag = 16'h0000; solved = 1'b0;

    // Enter held for 10 cycles in WAIT_DIFF: exactly one step.
    sd_cnt = 0; row_cnt = 0; sw = 2'd0; enter = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (set_diff_flag) sd_cnt++;
      if (row_flag) row_cnt++;
    end
    check_int("held_enter_set_diff", sd_cnt, 1);
    check_int("held_enter_row", row_cnt, 0);
    check_int("held_enter_state", int'(state), 3);

    // Enter and new-game rising together in WAIT_ROW: new game wins.
    enter = 1'b0; tick();
    enter = 1'b1; new_game_btn = 1'b1; tick();
    check("simul_edges", sample(), '{flags: 8'h80, st: 3'd1, go: 1'b0, dp: 2'd0, mc: 8'd0});
    enter = 1'b0; new_game_btn = 1'b0;
    for (int i = 0; i < 10 && state != 3'd2; i++) tick();
    check_int("simul_to_wait_diff", int'(state), 2);

    // Move-count saturation: 256 accepted values on unlocked cell 0.
    press(2'd1);
    for (int m = 1; m <= 256; m++) begin
      press(2'd0); press(2'd0); press(2'd3); tick();
      if (m == 254) check_int("mc_254", int'(move_count), 254);
      if (m == 255) check_int("mc_255", int'(move_count), 255);
    end
    check_int("mc_saturated", int'(move_count), 255);
    check_int("after_moves_state", int'(state), 3);

    // Restart during CHECK cycle 1, with enter held through release.
    press(2'd0); press(2'd1);
    sw = 2'd2; enter = 1'b1; tick();
    check("check_cycle1", sample(), '{flags: 8'h06, st: 3'd6, go: 1'b0, dp: 2'd2, mc: 8'd255});
    restart = 1'b1; tick();
    check("restart_in_check", sample(), '0);
    restart = 1'b0; tick();
    check("after_restart", sample(), '0);
    new_game_btn = 1'b1; tick();
    new_game_btn = 1'b0;
    sd_cnt = 0;
    for (int i = 0; i < 10 && state != 3'd2; i++) begin
      tick();
      if (set_diff_flag) sd_cnt++;
    end
    repeat (3) begin
      tick();
      if (set_diff_flag) sd_cnt++;
    end
    check_int("held_at_release_no_step", sd_cnt, 0);
    check_int("held_at_release_state", int'(state), 2);
    enter = 1'b0; tick();
    sw = 2'd3; enter = 1'b1; tick();
    o = sample();
    check("fresh_enter_after_release", o, '{flags: 8'h20, st: 3'd3, go: 1'b0, dp: 2'd3, mc: 8'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
